// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the fetch/data memory-port arbiter.
package mem_arb_pkg;

  localparam int DEFAULT_TIMEOUT = 64;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BUS_IF   = 3'd1;
  localparam logic [2:0] ST_BUS_MEM  = 3'd2;
  localparam logic [2:0] ST_RESP_IF  = 3'd3;
  localparam logic [2:0] ST_RESP_MEM = 3'd4;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } requester_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Bus watchdog: clearable, saturating cycle counter that flags the last allowed cycle.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_r;

  // Count cycles spent waiting on the bus, holding at the last value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LAST_C)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_C);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and data access,
// one transaction at a time, with round-robin tie breaking and a hung-bus watchdog.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_be,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_ack,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [2:0]        state_r;
  requester_e        last_grant_r;
  requester_e        winner_s;
  logic              grant_s;
  logic              timer_clr_s;
  logic              timer_en_s;
  logic              expired_s;
  logic              in_bus_s;
  logic              if_ack_r, if_err_r, mem_ack_r, mem_err_r;
  logic [DATA_W-1:0] if_rdata_r, mem_rdata_r;
  logic              bus_req_r, bus_we_r;
  logic [BE_W-1:0]   bus_be_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;

  assign in_bus_s    = (state_r == ST_BUS_IF) || (state_r == ST_BUS_MEM);
  assign timer_clr_s = (state_r == ST_IDLE);
  assign timer_en_s  = in_bus_s && !bus_ack;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (expired_s)
  );

  // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_s  = if_req || mem_req;
    winner_s = REQ_FETCH;
    if (if_req && mem_req) begin
      winner_s = (last_grant_r == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (mem_req) begin
      winner_s = REQ_DATA;
    end else begin
      winner_s = REQ_FETCH;
    end
  end

  // Transaction sequencer and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= REQ_FETCH;
      if_ack_r     <= 1'b0;
      if_err_r     <= 1'b0;
      if_rdata_r   <= '0;
      mem_ack_r    <= 1'b0;
      mem_err_r    <= 1'b0;
      mem_rdata_r  <= '0;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_be_r     <= '0;
      bus_addr_r   <= '0;
      bus_wdata_r  <= '0;
    end else begin
      if_ack_r  <= 1'b0;
      if_err_r  <= 1'b0;
      mem_ack_r <= 1'b0;
      mem_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            last_grant_r <= winner_s;
            bus_req_r    <= 1'b1;
            if (winner_s == REQ_DATA) begin
              state_r     <= ST_BUS_MEM;
              bus_we_r    <= mem_we;
              bus_be_r    <= mem_be;
              bus_addr_r  <= mem_addr;
              bus_wdata_r <= mem_wdata;
            end else begin
              state_r     <= ST_BUS_IF;
              bus_we_r    <= 1'b0;
              bus_be_r    <= {BE_W{1'b1}};
              bus_addr_r  <= if_addr;
              bus_wdata_r <= '0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS_IF, ST_BUS_MEM: begin
          // A real ack in the final watchdog cycle takes priority over the abort.
          if (bus_ack || expired_s) begin
            bus_req_r <= 1'b0;
            if (state_r == ST_BUS_IF) begin
              state_r    <= ST_RESP_IF;
              if_ack_r   <= 1'b1;
              if_err_r   <= !bus_ack;
              if_rdata_r <= bus_ack ? bus_rdata : '0;
            end else begin
              state_r     <= ST_RESP_MEM;
              mem_ack_r   <= 1'b1;
              mem_err_r   <= !bus_ack;
              mem_rdata_r <= bus_ack ? bus_rdata : '0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_RESP_IF, ST_RESP_MEM: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          bus_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_r;
  assign if_err    = if_err_r;
  assign if_rdata  = if_rdata_r;
  assign mem_ack   = mem_ack_r;
  assign mem_err   = mem_err_r;
  assign mem_rdata = mem_rdata_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_be    = bus_be_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: vector table plus multi-cycle sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_be;
  logic        if_ack, if_err, mem_ack, mem_err, bus_req, bus_we;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [137:0] out_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  assign out_s = {bus_req, bus_we, bus_be, bus_addr, bus_wdata,
                  if_ack, if_err, if_rdata, mem_ack, mem_err, mem_rdata};

  typedef struct {
    logic         rst, ireq;
    logic [31:0]  iaddr;
    logic         mreq, mwe;
    logic [3:0]   mbe;
    logic [31:0]  maddr, mwdata;
    logic         back;
    logic [31:0]  brdata;
    logic [137:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [137:0] expo(input logic breq, bwe, input logic [3:0] bbe,
                                        input logic [31:0] baddr, bwdata, input logic iack, ierr,
                                        input logic [31:0] irdata, input logic mack, merr,
                                        input logic [31:0] mrdata);
    return {breq, bwe, bbe, baddr, bwdata, iack, ierr, irdata, mack, merr, mrdata};
  endfunction

  task automatic addv(input logic rst, ireq, input logic [31:0] iaddr, input logic mreq, mwe,
                      input logic [3:0] mbe, input logic [31:0] maddr, mwdata,
                      input logic back, input logic [31:0] brdata, input logic [137:0] exp);
    vec_t v;
    v = '{rst, ireq, iaddr, mreq, mwe, mbe, maddr, mwdata, back, brdata, exp};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ireq, input logic [31:0] iaddr, input logic mreq, mwe,
                       input logic [3:0] mbe, input logic [31:0] maddr, mwdata,
                       input logic back, input logic [31:0] brdata);
    reset = rst; if_req = ireq; if_addr = iaddr; mem_req = mreq; mem_we = mwe;
    mem_be = mbe; mem_addr = maddr; mem_wdata = mwdata; bus_ack = back; bus_rdata = brdata;
  endtask

  initial begin
    int n;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Single fetch, store, then contention after reset with D,F,D,F alternation.
    addv(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b1, 1'b0, 4'hF, 32'h100,  32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b1, 1'b0, 4'hF, 32'h100,  32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b1, 32'hDEADBEEF,
         expo(1'b0, 1'b0, 4'hF, 32'h100,  32'h0,    1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'hF, 32'h100,  32'h0,    1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'hF, 32'h100,  32'h0,    1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h2000, 32'h1234, 1'b0, 32'h0,
         expo(1'b1, 1'b1, 4'h3, 32'h2000, 32'h1234, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 4'h3, 32'h2000, 32'h1234, 1'b1, 32'hCAFE0001,
         expo(1'b0, 1'b1, 4'h3, 32'h2000, 32'h1234, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'hCAFE0001));
    addv(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b1, 4'h3, 32'h2000, 32'h1234, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hCAFE0001));
    addv(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b1, 32'h11,
         expo(1'b0, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h11));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h11));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b1, 1'b0, 4'hF, 32'h300,  32'h0,    1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h11));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b1, 32'h22,
         expo(1'b0, 1'b0, 4'hF, 32'h300,  32'h0,    1'b1, 1'b0, 32'h22,       1'b0, 1'b0, 32'h11));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'hF, 32'h300,  32'h0,    1'b0, 1'b0, 32'h22,       1'b0, 1'b0, 32'h11));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 1'b0, 32'h22,       1'b0, 1'b0, 32'h11));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b1, 32'h33,
         expo(1'b0, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 1'b0, 32'h22,       1'b1, 1'b0, 32'h33));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 1'b0, 32'h22,       1'b0, 1'b0, 32'h33));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b0, 32'h0,
         expo(1'b1, 1'b0, 4'hF, 32'h300,  32'h0,    1'b0, 1'b0, 32'h22,       1'b0, 1'b0, 32'h33));
    addv(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 4'hF, 32'h400,  32'h0,    1'b1, 32'h44,
         expo(1'b0, 1'b0, 4'hF, 32'h300,  32'h0,    1'b1, 1'b0, 32'h44,       1'b0, 1'b0, 32'h33));
    addv(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,    32'h0,    1'b0, 32'h0,
         expo(1'b0, 1'b0, 4'hF, 32'h300,  32'h0,    1'b0, 1'b0, 32'h44,       1'b0, 1'b0, 32'h33));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].mreq, vecs[i].mwe, vecs[i].mbe,
            vecs[i].maddr, vecs[i].mwdata, vecs[i].back, vecs[i].brdata);
      tick();
      check($sformatf("vec%0d", i), out_s, vecs[i].exp);
    end

    // Watchdog: bus never acks, bus_req must stay high exactly TIMEOUT cycles.
    drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    n = 0;
    while (bus_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("timeout_len", 138'(n), 138'(4));
    check("timeout_resp", 138'({if_ack, if_err, if_rdata}), 138'({1'b1, 1'b1, 32'h0}));
    if_req = 1'b0;
    tick();
    check("timeout_after", 138'({if_ack, if_err, bus_req}), 138'(3'b000));
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0, 1'b0, 32'h0);
    tick();
    check("post_to_issue", 138'({bus_req, bus_we, bus_addr}), 138'({1'b1, 1'b0, 32'h600}));
    bus_ack = 1'b1; bus_rdata = 32'h77;
    tick();
    check("post_to_resp", 138'({mem_ack, mem_err, mem_rdata}), 138'({1'b1, 1'b0, 32'h77}));
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();

    // Ack lands in the final watchdog cycle: must complete without error.
    drive(1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) tick();
    check("late_ack_pending", 138'({bus_req, if_ack}), 138'(2'b10));
    bus_ack = 1'b1; bus_rdata = 32'h99;
    tick();
    check("late_ack_resp", 138'({if_ack, if_err, if_rdata}), 138'({1'b1, 1'b0, 32'h99}));

    // Spurious bus_ack while idle.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hFFFF);
    tick();
    tick();
    check("spurious_ack", 138'({if_ack, mem_ack, bus_req, if_rdata}), 138'({3'b000, 32'h99}));
    bus_ack = 1'b0;
    tick();
    check("spurious_after", 138'({if_ack, mem_ack, mem_rdata}), 138'({2'b00, 32'h77}));

    // Reset while a store is on the bus.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hC, 32'h900, 32'hAB, 1'b0, 32'h0);
    tick();
    check("rst_mid_issue", 138'({bus_req, bus_we, bus_addr}), 138'({1'b1, 1'b1, 32'h900}));
    reset = 1'b1;
    tick();
    check("rst_mid_drop", 138'({bus_req, mem_ack, mem_err}), 138'(3'b000));
    reset = 1'b0; mem_req = 1'b0;
    tick();
    check("rst_mid_idle", 138'({bus_req, mem_ack, if_ack}), 138'(3'b000));
    drive(1'b0, 1'b1, 32'h700, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check("rst_fetch_issue", 138'({bus_req, bus_be, bus_addr}), 138'({1'b1, 4'hF, 32'h700}));
    bus_ack = 1'b1; bus_rdata = 32'h88;
    tick();
    check("rst_fetch_resp", 138'({if_ack, if_err, if_rdata, mem_ack}), 138'({1'b1, 1'b0, 32'h88, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory port between the fetch stage (instruction reads) and the mem stage (data loads/stores) of the pipelined RISC-V core.
- One transaction in flight at a time. Requests are latched, arbitration is fair under contention, response data is returned to the winner, and a watchdog terminates hung bus transactions so the core sees an error instead of a deadlock.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- TIMEOUT, 64, cycles bus_req may remain unacknowledged before abort; legal range 2..65535

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with stable if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse to fetch
- if_rdata  out  DATA_W  fetch read data, valid while if_ack
- if_err  out  1  fetch transaction aborted by timeout, coincident with if_ack
- mem_req  in  1  data request; held with stable payload until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_be  in  DATA_W/8  store byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_ack  out  1  one-cycle completion pulse to mem stage
- mem_rdata  out  DATA_W  load data, valid while mem_ack
- mem_err  out  1  data transaction aborted, coincident with mem_ack
- bus_req  out  1  external request; held until bus_ack or abort
- bus_we  out  1  registered copy of winner's we (0 for fetch)
- bus_be  out  DATA_W/8  byte enables (all ones for fetch)
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered store data (0 for fetch)
- bus_ack  in  1  external completion, one cycle
- bus_rdata  in  DATA_W  external read data, valid with bus_ack

Behaviour:
- Reset: state IDLE, last_grant = FETCH, timer 0; all outputs 0. Reset mid-transaction drops bus_req the next cycle, no ack/err to either requester, latched transaction discarded.
- States:
  - IDLE: the arbitration decision is sampled at the clock edge.
    - Neither request: stay in IDLE.
    - One request: grant it.
    - Both requests: grant the requester that is not last_grant. After reset, data wins the first tie.
    - On grant: latch the payload into the bus_* registers, set last_grant, clear the timer, go to BUS_IF or BUS_MEM.
  - BUS_x: bus_req = 1 and bus_* are stable.
    - bus_ack: capture bus_rdata, go to RESP_x.
    - Otherwise, timer == TIMEOUT-1: capture 0 as rdata, set the error flag, go to RESP_x.
    - Otherwise: increment the timer.
  - RESP_x: x_ack = 1 for exactly one cycle, x_rdata = captured data, x_err = abort flag. Go to IDLE.
- Latency: a request first seen in IDLE at edge N gives bus_req high in cycle N..; bus_ack in cycle M gives x_ack in cycle M+1. Minimum issue-to-issue spacing is 3 cycles; a requester's stale req during its ack cycle is never re-granted.
- bus_ack outside BUS_x is ignored. The bus_ack and timeout in the same cycle: bus_ack wins (no error).
- Requester dropping req while its transaction is in flight does not affect it; the ack is still delivered.
- x_rdata holds its value after ack until the next response to that requester. x_err and x_ack are 0 outside RESP_x.
- Timer width is the clog2(TIMEOUT) bits, saturating; no wrap.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, BUS_IF, BUS_MEM, RESP_IF, RESP_MEM}
  - requester enum {REQ_FETCH, REQ_DATA}
  - default TIMEOUT constant
- One sub-module, mem_arb_timer: clear/enable counter with expired output, parameterised by TIMEOUT.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, bus acks after 2 cycles with 0xDEADBEEF -> bus_we=0, bus_be=0xF, bus_addr=0x100; if_ack one cycle later with if_rdata=0xDEADBEEF, if_err=0.
- Store: mem_req, we=1, be=0x3, addr=0x2000, wdata=0x1234 -> bus_* match exactly; mem_ack after bus_ack; bus_req never seen by fetch side.
- Contention right after reset: both reqs asserted in the same cycle -> data granted first; fetch granted next. With both held continuously, grants alternate D,F,D,F over 4 transactions.
- Timeout with TIMEOUT=4: fetch request, bus never acks -> bus_req high for exactly 4 cycles; then if_ack=1, if_err=1, if_rdata=0; next request proceeds normally.
- Reset during BUS_MEM -> bus_req=0 the next cycle, no mem_ack, state IDLE; a fresh fetch request completes normally.
- Late ack: bus_ack in the final timeout cycle -> normal response, err=0. A spurious bus_ack in IDLE produces no ack to either requester.
